// File: rtl/reduce_n_way_pipe.sv
// Pipelined WIDTH-to-1 reduction (OR/AND/XOR/NOR) with optional multi-beat group folding.
// S1 holds the incoming beat, S2 is the result register; valid/ready on both sides.
module reduce_n_way_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [1:0]       s1_op;
  logic             s1_acc;
  logic             s1_last;

  logic [0:0]       state_q;
  logic [1:0]       op_q;
  logic             acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]       eff_op;
  logic             word_red;
  logic             folded;
  logic             final_bit;
  logic             closes;
  logic [CNT_W-1:0] cnt_next;
  logic             s1_adv;
  logic             load;

  // Inside a group the latched operator wins; in_acc=0 mid-group also closes it.
  always_comb begin
    eff_op = (state_q == ACCUM) ? op_q : s1_op;

    word_red = 1'b0;
    case (eff_op)
      OP_OR, OP_NOR: word_red = |s1_data;
      OP_AND:        word_red = &s1_data;
      default:       word_red = ^s1_data;
    endcase

    folded = word_red;
    if (state_q == ACCUM) begin
      case (eff_op)
        OP_AND:  folded = acc_q & word_red;
        OP_XOR:  folded = acc_q ^ word_red;
        default: folded = acc_q | word_red;
      endcase
    end

    final_bit = (eff_op == OP_NOR) ? ~folded : folded;
    closes    = !s1_acc || s1_last;

    cnt_next = CNT_ONE;
    if (state_q == ACCUM) begin
      cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end
  end

  // Non-closing beats never touch the output register, so they keep flowing under backpressure.
  assign s1_adv   = s1_valid && (!closes || !out_valid || out_ready);
  assign load     = s1_adv && closes;
  assign in_ready = !s1_valid || s1_adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_op    <= OP_OR;
      s1_acc   <= 1'b0;
      s1_last  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in;
        s1_op   <= in_op;
        s1_acc  <= in_acc;
        s1_last <= in_last;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_OR;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (s1_adv) begin
      if (closes) begin
        state_q <= IDLE;
        acc_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        if (state_q == IDLE) begin
          op_q <= s1_op;
        end
        state_q <= ACCUM;
        acc_q   <= folded;
        cnt_q   <= cnt_next;
      end
    end
  end

  // A take and a load on the same edge leave out_valid high with the new result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= 1'b0;
      out_beats <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out       <= final_bit;
      out_beats <= cnt_next;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reduce_n_way_pipe.sv
// Directed bench for reduce_n_way_pipe; a CNT_W=2 copy shares the stimulus to expose counter saturation.
module tb_reduce_n_way_pipe;

  localparam int WIDTH  = 16;
  localparam int BUDGET = 50;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in;
  logic [1:0]       in_op;
  logic             in_acc;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic             out;
  logic [7:0]       out_beats;
  logic             out_valid;
  logic             out_ready;

  logic             in_ready_s;
  logic             out_s;
  logic [1:0]       out_beats_s;
  logic             out_valid_s;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int accept_cyc;

  logic res_out[$];
  int   res_beats[$];
  int   res_cyc[$];
  logic res2_out[$];
  int   res2_beats[$];

  always #5 clk = ~clk;

  reduce_n_way_pipe #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in(in), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_beats(out_beats),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  reduce_n_way_pipe #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in(in), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready_s), .out(out_s), .out_beats(out_beats_s),
    .out_valid(out_valid_s), .out_ready(out_ready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Log every result the sink takes on the coming edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      res_out.push_back(out);
      res_beats.push_back(int'(out_beats));
      res_cyc.push_back(cyc);
      res2_out.push_back(out_s);
      res2_beats.push_back(int'(out_beats_s));
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic [1:0] op,
                               input logic acc, input logic last, output int waits);
    bit accepted;
    in       = data;
    in_op    = op;
    in_acc   = acc;
    in_last  = last;
    in_valid = 1'b1;
    waits    = 0;
    accepted = 1'b0;
    while (!accepted && waits < BUDGET) begin
      @(negedge clk);
      if (in_ready) begin
        accept_cyc = cyc;
        accepted   = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic goIdle();
    in_valid = 1'b0;
    in_acc   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearResults();
    res_out.delete();
    res_beats.delete();
    res_cyc.delete();
    res2_out.delete();
    res2_beats.delete();
  endtask

  logic [WIDTH-1:0] t1_word[6] = '{16'h0000, 16'h0100, 16'hFFFF, 16'hFFFE, 16'h0003, 16'h0000};
  logic [1:0]       t1_op[6]   = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
  logic             t1_exp[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic             t4_exp[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int w;
    int total_waits;
    int first_acc;

    reset     = 1'b1;
    in        = '0;
    in_op     = 2'b00;
    in_acc    = 1'b0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out", 32'(out), 32'd0);
    checkOutput("rst_out_beats", 32'(out_beats), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Single-beat groups back to back at full throughput
    out_ready = 1'b1;
    clearResults();
    total_waits = 0;
    first_acc   = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(t1_word[i], t1_op[i], 1'b0, 1'b0, w);
      if (i == 0) first_acc = accept_cyc;
      total_waits += w;
    end
    goIdle();
    waitCycles(6);
    checkOutput("t1_stalls", 32'(total_waits), 32'd0);
    checkOutput("t1_count", 32'(res_out.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < res_out.size()) begin
        checkOutput($sformatf("t1_out%0d", i), 32'(res_out[i]), 32'(t1_exp[i]));
        checkOutput($sformatf("t1_beats%0d", i), 32'(res_beats[i]), 32'd1);
        if (i == 0) checkOutput("t1_latency", 32'(res_cyc[0] - first_acc), 32'd2);
        else checkOutput($sformatf("t1_gap%0d", i), 32'(res_cyc[i] - res_cyc[i-1]), 32'd1);
      end
    end

    // Accumulated OR group and accumulated AND group
    clearResults();
    applyStimulus(16'h0000, 2'b00, 1'b1, 1'b0, w);
    applyStimulus(16'h0000, 2'b00, 1'b1, 1'b0, w);
    applyStimulus(16'h0040, 2'b00, 1'b1, 1'b1, w);
    applyStimulus(16'hFFFF, 2'b01, 1'b1, 1'b0, w);
    applyStimulus(16'hFFFE, 2'b01, 1'b1, 1'b0, w);
    applyStimulus(16'hFFFF, 2'b01, 1'b1, 1'b1, w);
    goIdle();
    waitCycles(6);
    checkOutput("t2_count", 32'(res_out.size()), 32'd2);
    if (res_out.size() >= 2) begin
      checkOutput("t2_or_out", 32'(res_out[0]), 32'd1);
      checkOutput("t2_or_beats", 32'(res_beats[0]), 32'd3);
      checkOutput("t2_and_out", 32'(res_out[1]), 32'd0);
      checkOutput("t2_and_beats", 32'(res_beats[1]), 32'd3);
    end

    // Operator changes mid-group are ignored
    clearResults();
    applyStimulus(16'h0001, 2'b10, 1'b1, 1'b0, w);
    applyStimulus(16'h0001, 2'b01, 1'b1, 1'b1, w);
    goIdle();
    waitCycles(5);
    checkOutput("t3_count", 32'(res_out.size()), 32'd1);
    if (res_out.size() >= 1) begin
      checkOutput("t3_out", 32'(res_out[0]), 32'd0);
      checkOutput("t3_beats", 32'(res_beats[0]), 32'd2);
    end

    // Backpressure: one result pending, three more groups queued behind it
    clearResults();
    out_ready = 1'b0;
    fork
      begin
        applyStimulus(16'h0001, 2'b00, 1'b0, 1'b0, w);
        applyStimulus(16'h0000, 2'b00, 1'b0, 1'b0, w);
        applyStimulus(16'hFFFF, 2'b01, 1'b0, 1'b0, w);
        applyStimulus(16'h0000, 2'b11, 1'b0, 1'b0, w);
        goIdle();
      end
      begin
        repeat (6) @(negedge clk);
        checkOutput("t4_in_ready_low", 32'(in_ready), 32'd0);
        checkOutput("t4_held_valid", 32'(out_valid), 32'd1);
        checkOutput("t4_held_out", 32'(out), 32'd1);
        checkOutput("t4_held_beats", 32'(out_beats), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("t4_still_out", 32'(out), 32'd1);
        checkOutput("t4_still_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    waitCycles(6);
    checkOutput("t4_count", 32'(res_out.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < res_out.size()) begin
        checkOutput($sformatf("t4_out%0d", i), 32'(res_out[i]), 32'(t4_exp[i]));
        checkOutput($sformatf("t4_beats%0d", i), 32'(res_beats[i]), 32'd1);
      end
    end

    // Six-beat XOR group: CNT_W=2 copy saturates at 3
    clearResults();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(16'h0001, 2'b10, 1'b1, (i == 5), w);
    end
    goIdle();
    waitCycles(5);
    checkOutput("t5_count", 32'(res_out.size()), 32'd1);
    if (res_out.size() >= 1) begin
      checkOutput("t5_out", 32'(res_out[0]), 32'd0);
      checkOutput("t5_beats_w8", 32'(res_beats[0]), 32'd6);
      checkOutput("t5_sat_out", 32'(res2_out[0]), 32'd0);
      checkOutput("t5_sat_beats", 32'(res2_beats[0]), 32'd3);
    end

    // Reset in the middle of a group discards it
    clearResults();
    applyStimulus(16'h0001, 2'b00, 1'b1, 1'b0, w);
    applyStimulus(16'h0001, 2'b00, 1'b1, 1'b0, w);
    goIdle();
    waitCycles(2);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t6_in_ready", 32'(in_ready), 32'd1);
    checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    applyStimulus(16'h8000, 2'b00, 1'b0, 1'b0, w);
    goIdle();
    waitCycles(5);
    checkOutput("t6_count", 32'(res_out.size()), 32'd1);
    if (res_out.size() >= 1) begin
      checkOutput("t6_out", 32'(res_out[0]), 32'd1);
      checkOutput("t6_beats", 32'(res_beats[0]), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "[TB] timeout");
  end

endmodule
